// File: rtl/twos_complement_adder.sv
// Registered two's-complement adder/subtractor: one ripple-carry stage with valid qualification.
// Optional signed-overflow flag is built only when TWOS_ADDER_OVF_EN is defined.
module twos_complement_adder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] w_bx;
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    logic             r_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    // Subtract is a + ~b + 1: invert B and inject the +1 as carry-in.
    assign w_bx       = b ^ {WIDTH{m}};
    assign w_carry[0] = m;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic w_p;
        assign w_p            = a[i] ^ w_bx[i];
        assign w_sum[i]       = w_p ^ w_carry[i];
        assign w_carry[i + 1] = (a[i] & w_bx[i]) | (w_p & w_carry[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
        end
    end

    // Result registers load only on valid input, so X on idle inputs never reaches them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (in_valid) begin
            r_sum  <= w_sum;
            r_cout <= w_carry[WIDTH];
        end
    end

`ifdef TWOS_ADDER_OVF_EN
    logic w_ovf;
    logic r_ovf;

    assign w_ovf = w_carry[WIDTH] ^ w_carry[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (in_valid) begin
            r_ovf <= w_ovf;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign out_valid = r_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule

// File: tb/tb_twos_complement_adder.sv
// Directed and exhaustive bench for twos_complement_adder at WIDTH=4.
// Expected ovf follows TWOS_ADDER_OVF_EN, compiled with the same defines as the design.
module tb_twos_complement_adder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       m;
    logic       out_valid;
    logic [3:0] sum;
    logic       cout;
    logic       ovf;

    int checks;
    int errors;

    twos_complement_adder #(
        .WIDTH(4)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .m        (m),
        .out_valid(out_valid),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ovf_exp(input logic v);
`ifdef TWOS_ADDER_OVF_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    // Drive one valid op at a negedge and check its result at the next negedge.
    task automatic op(input string tag, input logic [3:0] ia, input logic [3:0] ib, input logic im,
                      input logic [3:0] esum, input logic ecout, input logic eovf);
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        m        = im;
        @(negedge clk);
        chk({tag, ".sum"}, 32'(sum), 32'(esum));
        chk({tag, ".cout"}, 32'(cout), 32'(ecout));
        chk({tag, ".ovf"}, 32'(ovf), 32'(ovf_exp(eovf)));
        chk({tag, ".vld"}, 32'(out_valid), 32'd1);
    endtask

    // Arithmetic reference: 5-bit sum of a, effective b and carry-in; ovf from operand/result signs.
    function automatic logic [5:0] model(input logic [3:0] ia, input logic [3:0] ib, input logic im);
        logic [3:0] bx;
        logic [4:0] r;
        logic       v;
        bx = im ? ~ib : ib;
        r  = {1'b0, ia} + {1'b0, bx} + {4'd0, im};
        v  = (ia[3] == bx[3]) && (r[3] != ia[3]);
        return {ovf_exp(v), r};
    endfunction

    initial begin
        logic [5:0] exp_r;
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 4'd0;
        b        = 4'd0;
        m        = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst.sum", 32'(sum), 32'd0);
        chk("rst.cout", 32'(cout), 32'd0);
        chk("rst.ovf", 32'(ovf), 32'd0);
        chk("rst.vld", 32'(out_valid), 32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        chk("rel.sum", 32'(sum), 32'd0);
        chk("rel.vld", 32'(out_valid), 32'd0);

        op("add1", 4'b1010, 4'b1100, 1'b0, 4'b0110, 1'b1, 1'b1);
        op("add2", 4'b1000, 4'b0100, 1'b0, 4'b1100, 1'b0, 1'b0);
        op("add3", 4'b1010, 4'b0010, 1'b0, 4'b1100, 1'b0, 1'b0);
        op("sub1", 4'b1111, 4'b1010, 1'b1, 4'b0101, 1'b1, 1'b0);
        op("sub2", 4'b1010, 4'b0110, 1'b1, 4'b0100, 1'b1, 1'b1);
        op("sub3", 4'b1001, 4'b0100, 1'b1, 4'b0101, 1'b1, 1'b1);
        op("borrow", 4'b0010, 4'b0101, 1'b1, 4'b1101, 1'b0, 1'b0);
        op("wrap", 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
        op("posovf", 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
        op("subzero", 4'b0110, 4'b0000, 1'b1, 4'b0110, 1'b1, 1'b0);
        op("minneg", 4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1);

        // Idle cycles with garbage on the operands must hold the last result.
        in_valid = 1'b0;
        a        = 4'bxxxx;
        b        = 4'bxxxx;
        m        = 1'bx;
        @(negedge clk);
        chk("idle1.sum", 32'(sum), 32'(4'b0111));
        chk("idle1.cout", 32'(cout), 32'd1);
        chk("idle1.ovf", 32'(ovf), 32'(ovf_exp(1'b1)));
        chk("idle1.vld", 32'(out_valid), 32'd0);
        a = 4'b0011;
        b = 4'b0101;
        m = 1'b0;
        @(negedge clk);
        chk("idle2.sum", 32'(sum), 32'(4'b0111));
        chk("idle2.vld", 32'(out_valid), 32'd0);

        op("b2b1", 4'b0001, 4'b0010, 1'b0, 4'b0011, 1'b0, 1'b0);
        op("b2b2", 4'b0101, 4'b0011, 1'b1, 4'b0010, 1'b1, 1'b0);
        op("b2b3", 4'b0100, 4'b0100, 1'b0, 4'b1000, 1'b0, 1'b1);
        op("b2b4", 4'b0000, 4'b0001, 1'b1, 4'b1111, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b.drop", 32'(out_valid), 32'd0);

        // Reset mid-stream: in-flight op is discarded and outputs clear at once.
        in_valid = 1'b1;
        a        = 4'b1111;
        b        = 4'b1111;
        m        = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid.sum", 32'(sum), 32'd0);
        chk("mid.cout", 32'(cout), 32'd0);
        chk("mid.ovf", 32'(ovf), 32'd0);
        chk("mid.vld", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("mid2.sum", 32'(sum), 32'd0);
        chk("mid2.vld", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        chk("mid3.sum", 32'(sum), 32'd0);
        chk("mid3.vld", 32'(out_valid), 32'd0);

        for (int im = 0; im < 2; im++) begin
            for (int ia = 0; ia < 16; ia++) begin
                for (int ib = 0; ib < 16; ib++) begin
                    in_valid = 1'b1;
                    a        = 4'(ia);
                    b        = 4'(ib);
                    m        = 1'(im);
                    exp_r    = model(4'(ia), 4'(ib), 1'(im));
                    @(negedge clk);
                    chk("exh.sum", 32'(sum), 32'(exp_r[3:0]));
                    chk("exh.cout", 32'(cout), 32'(exp_r[4]));
                    chk("exh.ovf", 32'(ovf), 32'(exp_r[5]));
                    chk("exh.vld", 32'(out_valid), 32'd1);
                end
            end
        end
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
